// File: rtl/pcie_ss_axis_chk_if.sv
// PCIe SS AXI-Stream bundle observed by pcie_ss_axis_chk.
// master/slave modports describe the real link endpoints; the monitor
// modport is the all-input view used by the passive checker.
interface pcie_ss_axis_chk_if #(
    parameter int DATA_W = 512,
    parameter int USER_W = 10
) ();
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [DATA_W-1:0]     tdata;
    logic [DATA_W/8-1:0]   tkeep;
    logic [USER_W-1:0]     tuser_vendor;

    modport master  (output tvalid, tlast, tdata, tkeep, tuser_vendor, input tready);
    modport slave   (input tvalid, tlast, tdata, tkeep, tuser_vendor, output tready);
    modport monitor (input tvalid, tready, tlast, tdata, tkeep, tuser_vendor);
endinterface

// File: rtl/pcie_ss_axis_chk.sv
// pcie_ss_axis_chk: passive AXI-Stream protocol checker and traffic monitor.
// Checks handshake stability, tkeep shape and packet length, keeps sticky
// error flags with first-error capture and an irq pulse, and counts packets
// and beats. Optional stall watchdog: define PCIE_SS_AXIS_CHK_TIMEOUT_EN.
// Error bits: [0] VALID_DROP [1] PAYLOAD_CHANGE [2] KEEP_ZERO [3] KEEP_HOLE
//             [4] PKT_TOO_LONG [5] STALL_TIMEOUT
module pcie_ss_axis_chk #(
    parameter int DATA_W         = 512,
    parameter int USER_W         = 10,
    parameter int MAX_PKT_BEATS  = 64,
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    pcie_ss_axis_chk_if.monitor     axis,
    input  logic                    clr_err_i,
    output logic [5:0]              err_vec_o,
    output logic [5:0]              err_first_o,
    output logic                    err_irq_o,
    output logic                    in_pkt_o,
    output logic [CNT_W-1:0]        pkt_cnt_o,
    output logic [CNT_W-1:0]        beat_cnt_o
);
    localparam int KEEP_W  = DATA_W / 8;
    // Beat counter must hold MAX_PKT_BEATS+1 (saturation point past the limit).
    localparam int BEATS_W = $clog2(MAX_PKT_BEATS + 2);
    localparam int TO_W    = ($clog2(TIMEOUT_CYCLES + 1) > 16) ? $clog2(TIMEOUT_CYCLES + 1) : 16;
    localparam logic [BEATS_W-1:0] BEATS_MAX  = BEATS_W'(MAX_PKT_BEATS);
    localparam logic [BEATS_W-1:0] BEATS_SAT  = BEATS_W'(MAX_PKT_BEATS + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OPEN = 1'b1
    } state_t;

    // True when k is of the form 2^n-1 (all set bits packed from bit 0).
    function automatic logic keep_contig(input logic [KEEP_W-1:0] k);
        return ((k & (k + KEEP_W'(1))) == '0);
    endfunction

    logic                accept_s;
    logic                stall_s;
    logic                payload_diff_s;
    logic                timeout_s;
    logic [5:0]          new_err_s;
    logic [5:0]          err_base_s;

    logic                stall_q, stall_d;
    logic [DATA_W-1:0]   cap_data_q;
    logic [KEEP_W-1:0]   cap_keep_q;
    logic                cap_last_q;
    logic [USER_W-1:0]   cap_user_q;

    state_t              state_q, state_d;
    logic [BEATS_W-1:0]  pkt_beats_q, pkt_beats_d;
    logic                in_pkt_q, in_pkt_d;
    logic [CNT_W-1:0]    pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [5:0]          err_vec_q, err_vec_d;
    logic [5:0]          err_first_q, err_first_d;
    logic                err_irq_q, err_irq_d;

    assign accept_s = axis.tvalid && axis.tready;
    assign stall_s  = axis.tvalid && !axis.tready;

    assign payload_diff_s = (axis.tdata        != cap_data_q) ||
                            (axis.tkeep        != cap_keep_q) ||
                            (axis.tlast        != cap_last_q) ||
                            (axis.tuser_vendor != cap_user_q);

`ifdef PCIE_SS_AXIS_CHK_TIMEOUT_EN
    logic [TO_W-1:0] stall_cnt_q, stall_cnt_d;

    // Count consecutive stall cycles; park at the threshold so it fires once.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_s) begin
            if (stall_cnt_q != TO_W'(TIMEOUT_CYCLES)) begin
                stall_cnt_d = stall_cnt_q + TO_W'(1);
            end else begin
                stall_cnt_d = stall_cnt_q;
            end
        end else begin
            stall_cnt_d = '0;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // The stall that brings the count to TIMEOUT_CYCLES raises the error.
    assign timeout_s = stall_s && (stall_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
    logic [TO_W-1:0] unused_to_s;
    assign unused_to_s = '0;
    assign timeout_s   = 1'b0;
`endif

    // Per-cycle error detection from the live bus and captured stall copy.
    always_comb begin
        new_err_s    = 6'b000000;
        new_err_s[0] = stall_q && !axis.tvalid;
        new_err_s[1] = stall_q && axis.tvalid && payload_diff_s;
        new_err_s[2] = axis.tvalid && (axis.tkeep == '0);
        new_err_s[3] = axis.tvalid && (axis.tkeep != '0) &&
                       (!keep_contig(axis.tkeep) || (!axis.tlast && (axis.tkeep != '1)));
        // pkt_beats saturates one past the limit, so equality fires once per packet.
        new_err_s[4] = accept_s && (pkt_beats_q == BEATS_MAX);
        new_err_s[5] = timeout_s;
    end

    // Stall flag: set on stall, cleared by accept or by tvalid low.
    always_comb begin
        stall_d = stall_s;
    end

    // Capture the payload on every stall cycle for the next-cycle comparison.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q    <= 1'b0;
            cap_data_q <= '0;
            cap_keep_q <= '0;
            cap_last_q <= 1'b0;
            cap_user_q <= '0;
        end else begin
            stall_q <= stall_d;
            if (stall_s) begin
                cap_data_q <= axis.tdata;
                cap_keep_q <= axis.tkeep;
                cap_last_q <= axis.tlast;
                cap_user_q <= axis.tuser_vendor;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a non-last accept opens a packet, a last accept closes it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && !axis.tlast) begin
                    state_d = ST_OPEN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OPEN: begin
                if (accept_s && axis.tlast) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_OPEN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: per-packet beat count and the registered in_pkt flag.
    always_comb begin
        pkt_beats_d = pkt_beats_q;
        in_pkt_d    = (state_d == ST_OPEN);
        case (state_q)
            ST_IDLE: begin
                if (accept_s && !axis.tlast) begin
                    pkt_beats_d = BEATS_W'(1);
                end else begin
                    pkt_beats_d = '0;
                end
            end
            ST_OPEN: begin
                if (accept_s && axis.tlast) begin
                    pkt_beats_d = '0;
                end else if (accept_s && (pkt_beats_q != BEATS_SAT)) begin
                    pkt_beats_d = pkt_beats_q + BEATS_W'(1);
                end else begin
                    pkt_beats_d = pkt_beats_q;
                end
            end
            default: pkt_beats_d = '0;
        endcase
    end

    // Saturating packet and beat counters; untouched by clr_err.
    always_comb begin
        pkt_cnt_d  = pkt_cnt_q;
        beat_cnt_d = beat_cnt_q;
        if (accept_s && axis.tlast && (pkt_cnt_q != '1)) begin
            pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
        end else begin
            pkt_cnt_d = pkt_cnt_q;
        end
        if (accept_s && (beat_cnt_q != '1)) begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end else begin
            beat_cnt_d = beat_cnt_q;
        end
    end

    // Sticky errors: clear first, then OR in new errors so a same-cycle error survives.
    always_comb begin
        err_base_s  = clr_err_i ? 6'b000000 : err_vec_q;
        err_vec_d   = err_base_s | new_err_s;
        err_first_d = err_first_q;
        err_irq_d   = 1'b0;
        if ((err_base_s == 6'b000000) && (new_err_s != 6'b000000)) begin
            err_first_d = new_err_s;
            err_irq_d   = 1'b1;
        end else begin
            err_first_d = clr_err_i ? 6'b000000 : err_first_q;
            err_irq_d   = 1'b0;
        end
    end

    // Output and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_beats_q <= '0;
            in_pkt_q    <= 1'b0;
            pkt_cnt_q   <= '0;
            beat_cnt_q  <= '0;
            err_vec_q   <= 6'b000000;
            err_first_q <= 6'b000000;
            err_irq_q   <= 1'b0;
        end else begin
            pkt_beats_q <= pkt_beats_d;
            in_pkt_q    <= in_pkt_d;
            pkt_cnt_q   <= pkt_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            err_vec_q   <= err_vec_d;
            err_first_q <= err_first_d;
            err_irq_q   <= err_irq_d;
        end
    end

    assign err_vec_o   = err_vec_q;
    assign err_first_o = err_first_q;
    assign err_irq_o   = err_irq_q;
    assign in_pkt_o    = in_pkt_q;
    assign pkt_cnt_o   = pkt_cnt_q;
    assign beat_cnt_o  = beat_cnt_q;
endmodule

// File: tb/tb_pcie_ss_axis_chk.sv
// Testbench for pcie_ss_axis_chk: table-driven single-cycle vectors plus
// hand-written sequences for clean traffic, oversized packets and (when
// PCIE_SS_AXIS_CHK_TIMEOUT_EN is defined) the stall watchdog.
module tb_pcie_ss_axis_chk;
    localparam int DATA_W = 512;
    localparam int USER_W = 10;
    localparam int KEEP_W = DATA_W / 8;
    localparam logic [DATA_W-1:0] BASE = {16{32'hA5A5_5A5A}};
    localparam logic [63:0]       FULL = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr_err = 1'b0;
    logic [5:0]  ev, ef, ev_s, ef_s;
    logic        irq, irq_s, inp, inp_s;
    logic [31:0] pc, bc, pc_s, bc_s;

    int n_chk  = 0;
    int n_fail = 0;

    pcie_ss_axis_chk_if #(.DATA_W(DATA_W), .USER_W(USER_W)) axis ();

    // Main instance: 64-beat packet limit.
    pcie_ss_axis_chk #(.DATA_W(DATA_W), .USER_W(USER_W), .MAX_PKT_BEATS(64),
                       .CNT_W(32), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .axis(axis), .clr_err_i(clr_err),
        .err_vec_o(ev), .err_first_o(ef), .err_irq_o(irq), .in_pkt_o(inp),
        .pkt_cnt_o(pc), .beat_cnt_o(bc));

    // Second instance on the same bus with a 4-beat limit.
    pcie_ss_axis_chk #(.DATA_W(DATA_W), .USER_W(USER_W), .MAX_PKT_BEATS(4),
                       .CNT_W(32), .TIMEOUT_CYCLES(8)) dut_s (
        .clk(clk), .rst(rst), .axis(axis), .clr_err_i(clr_err),
        .err_vec_o(ev_s), .err_first_o(ef_s), .err_irq_o(irq_s), .in_pkt_o(inp_s),
        .pkt_cnt_o(pc_s), .beat_cnt_o(bc_s));

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic        rdy;
        logic        last;
        logic        flip;
        logic        clr;
        logic [63:0] keep;
        logic [5:0]  ev;
        logic [5:0]  ef;
        logic        irq;
        logic        inp;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic rdy, input logic last,
                         input logic [DATA_W-1:0] d, input logic [63:0] k);
        axis.tvalid       = vld;
        axis.tready       = rdy;
        axis.tlast        = last;
        axis.tdata        = d;
        axis.tkeep        = k[KEEP_W-1:0];
        axis.tuser_vendor = 10'h155;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, BASE, FULL);
        clr_err = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Hold one beat on the bus until accepted; at most 3 random stalls per beat.
    task automatic send_beat(input logic [DATA_W-1:0] d, input logic [63:0] k,
                             input logic last, input logic bp);
        int   stalls = 0;
        logic done   = 1'b0;
        axis.tvalid = 1'b1;
        axis.tdata  = d;
        axis.tkeep  = k[KEEP_W-1:0];
        axis.tlast  = last;
        while (!done) begin
            if (bp && (stalls < 3)) axis.tready = 1'($urandom_range(0, 1));
            else                    axis.tready = 1'b1;
            tick();
            if (axis.tready) done = 1'b1;
            else             stalls++;
        end
    endtask

    initial begin
        int lens [3];
        int irq_cnt;
        logic [DATA_W-1:0] d;
        logic lst;

        // {vld, rdy, last, flip, clr, keep, exp err_vec, exp err_first, exp irq, exp in_pkt}
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, FULL,                 6'b000000, 6'b000000, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, FULL,                 6'b000000, 6'b000000, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0000_0000_0000_00FF, 6'b000000, 6'b000000, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0,                6'b000100, 6'b000100, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, FULL,                 6'b000100, 6'b000100, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, FULL,                 6'b000000, 6'b000000, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0000_0000_0000_00F0, 6'b001000, 6'b001000, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0000_0000_0000_00FF, 6'b001000, 6'b001000, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 64'h0,                6'b000100, 6'b000100, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, FULL,                 6'b000000, 6'b000000, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, FULL,                 6'b000000, 6'b000000, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, FULL,                 6'b000000, 6'b000000, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, FULL,                 6'b000001, 6'b000001, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, FULL,                 6'b000001, 6'b000001, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, FULL,                 6'b000000, 6'b000000, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, FULL,                 6'b000000, 6'b000000, 1'b0, 1'b0};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0000_0000_0000_0F0F, 6'b001010, 6'b001010, 1'b1, 1'b0};
        tbl[17] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, FULL,                 6'b001010, 6'b001010, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, FULL,                 6'b000000, 6'b000000, 1'b0, 1'b0};

        // Reset state, then reset in the middle of an open packet.
        do_reset();
        chk("rst.err_vec", 64'(ev), 64'h0);
        chk("rst.err_first", 64'(ef), 64'h0);
        chk("rst.err_irq", 64'(irq), 64'h0);
        chk("rst.in_pkt", 64'(inp), 64'h0);
        chk("rst.pkt_cnt", 64'(pc), 64'h0);
        chk("rst.beat_cnt", 64'(bc), 64'h0);
        drive(1'b1, 1'b1, 1'b0, BASE, FULL);
        tick();
        chk("open.in_pkt", 64'(inp), 64'h1);
        chk("open.beat_cnt", 64'(bc), 64'h1);
        rst = 1'b1;
        #2;
        chk("midrst.in_pkt", 64'(inp), 64'h0);
        chk("midrst.beat_cnt", 64'(bc), 64'h0);
        chk("midrst.err_vec", 64'(ev), 64'h0);
        do_reset();

        // Table-driven single-cycle vectors.
        for (int i = 0; i < 19; i++) begin
            d = BASE;
            d[0] = BASE[0] ^ tbl[i].flip;
            drive(tbl[i].vld, tbl[i].rdy, tbl[i].last, d, tbl[i].keep);
            clr_err = tbl[i].clr;
            tick();
            chk($sformatf("vec%0d.err_vec", i),   64'(ev),  64'(tbl[i].ev));
            chk($sformatf("vec%0d.err_first", i), 64'(ef),  64'(tbl[i].ef));
            chk($sformatf("vec%0d.err_irq", i),   64'(irq), 64'(tbl[i].irq));
            chk($sformatf("vec%0d.in_pkt", i),    64'(inp), 64'(tbl[i].inp));
        end
        clr_err = 1'b0;
        chk("tbl.beat_cnt", 64'(bc), 64'd7);
        chk("tbl.pkt_cnt", 64'(pc), 64'd5);

        // Clean traffic: 1, 4 and 64 beat packets with random backpressure.
        do_reset();
        lens[0] = 1;
        lens[1] = 4;
        lens[2] = 64;
        for (int p = 0; p < 3; p++) begin
            for (int b = 0; b < lens[p]; b++) begin
                d = BASE;
                d[31:0] = 32'(p * 1000 + b);
                lst = (b == lens[p] - 1);
                send_beat(d, lst ? 64'h0000_0000_0000_00FF : FULL, lst, 1'b1);
                if ((p == 2) && (b == 10)) chk("clean.in_pkt_mid", 64'(inp), 64'h1);
            end
        end
        drive(1'b0, 1'b0, 1'b0, BASE, FULL);
        tick();
        chk("clean.err_vec", 64'(ev), 64'h0);
        chk("clean.pkt_cnt", 64'(pc), 64'd3);
        chk("clean.beat_cnt", 64'(bc), 64'd69);
        chk("clean.in_pkt", 64'(inp), 64'h0);

        // Oversized packet on the 4-beat-limit instance: 6 beats, tlast on beat 6.
        do_reset();
        irq_cnt = 0;
        for (int b = 1; b <= 6; b++) begin
            send_beat(BASE, FULL, (b == 6), 1'b0);
            irq_cnt += int'(irq_s);
            if (b == 4) begin
                chk("long.b4_err_vec", 64'(ev_s), 64'h0);
                chk("long.b4_in_pkt", 64'(inp_s), 64'h1);
            end
            if (b == 5) begin
                chk("long.b5_err_vec", 64'(ev_s), 64'(6'b010000));
                chk("long.b5_err_first", 64'(ef_s), 64'(6'b010000));
                chk("long.b5_err_irq", 64'(irq_s), 64'h1);
            end
        end
        drive(1'b0, 1'b0, 1'b0, BASE, FULL);
        for (int c = 0; c < 3; c++) begin
            tick();
            irq_cnt += int'(irq_s);
        end
        chk("long.err_vec", 64'(ev_s), 64'(6'b010000));
        chk("long.irq_pulses", 64'(irq_cnt), 64'd1);
        chk("long.pkt_cnt", 64'(pc_s), 64'd1);
        chk("long.in_pkt", 64'(inp_s), 64'h0);
        chk("long.main_err_vec", 64'(ev), 64'h0);

`ifdef PCIE_SS_AXIS_CHK_TIMEOUT_EN
        // Eight consecutive stall cycles reach the 8-cycle watchdog.
        do_reset();
        drive(1'b1, 1'b0, 1'b0, BASE, FULL);
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 7) chk("to.c7_err_vec", 64'(ev), 64'h0);
        end
        chk("to.c8_err_vec", 64'(ev), 64'(6'b100000));
        chk("to.c8_err_first", 64'(ef), 64'(6'b100000));
        chk("to.c8_err_irq", 64'(irq), 64'h1);
        axis.tready = 1'b1;
        tick();
        chk("to.after_accept", 64'(ev), 64'(6'b100000));

        // Seven stall cycles then an accept: no timeout.
        do_reset();
        drive(1'b1, 1'b0, 1'b0, BASE, FULL);
        repeat (7) tick();
        axis.tready = 1'b1;
        tick();
        drive(1'b0, 1'b0, 1'b0, BASE, FULL);
        tick();
        chk("to.short_err_vec", 64'(ev), 64'h0);
`else
        // Without the watchdog, a long stall never sets bit 5.
        do_reset();
        drive(1'b1, 1'b0, 1'b0, BASE, FULL);
        repeat (12) tick();
        chk("nto.err_vec", 64'(ev), 64'h0);
        axis.tready = 1'b1;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
